// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_pkg
//  Description : Shared definitions for the ADC capture packer: capture state
//                encoding, lane-count helpers and the positions of the two
//                status bits carried at the top of every packed word.
//  Contents    : state_t       - IDLE / ARMED / CAPTURE / DONE
//                lanes_f       - samples per word, (WORD_WIDTH-2)/ADC_WIDTH
//                idx_width_f   - width of a lane index (at least one bit)
//                c_*           - status bit offsets measured down from the MSB
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package adc_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Two status bits sit above the sample lanes.
   localparam int c_status_bits = 2;
   // Offsets from the word MSB: OR flag at WORD_WIDTH-1, trigger at WORD_WIDTH-2.
   localparam int c_or_ofs      = 0;
   localparam int c_trig_ofs    = 1;

   function automatic int lanes_f(input int word_width, input int adc_width);
      return (word_width - c_status_bits) / adc_width;
   endfunction

   function automatic int idx_width_f(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_packer_if
//  Description : Word output bus of the capture packer towards the capture
//                FIFO write side (valid/ready handshake).
//  Signals     : word_o        packed word
//                word_valid_o  word_o holds a word
//                word_ready_i  downstream accepts (FIFO not full)
//  Modports    : master - packer side, slave - FIFO side
//  Revision    : 1.0  initial parametrised release
// ============================================================================
interface adc_capture_packer_if #(
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] word_o;
   logic                  word_valid_o;
   logic                  word_ready_i;

   modport master (
      output word_o,
      output word_valid_o,
      input  word_ready_i
   );

   modport slave (
      input  word_o,
      input  word_valid_o,
      output word_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/adc_word_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_word_outreg
//  Description : Single-entry valid/ready output register for packed words.
//                A load into a free (or simultaneously drained) register is
//                accepted; a load while the held word is stalled is dropped
//                and raises a sticky overflow flag.
//  Ports       : clk         clock
//                reset_i     synchronous active-low reset
//                load_i      a completed word is presented on word_i
//                word_i      completed word
//                clr_ovf_i   clear the sticky overflow flag
//                ready_i     downstream accepts the held word
//                word_o      held word
//                valid_o     word_o is valid
//                overflow_o  sticky: a completed word was dropped
//                drop_o      this cycle's load is being dropped
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module adc_word_outreg #(
   parameter int WORD_WIDTH = 32
) (
   input  wire logic                  clk,
   input  wire logic                  reset_i,
   input  wire logic                  load_i,
   input  wire logic [WORD_WIDTH-1:0] word_i,
   input  wire logic                  clr_ovf_i,
   input  wire logic                  ready_i,
   output logic      [WORD_WIDTH-1:0] word_o,
   output logic                       valid_o,
   output logic                       overflow_o,
   output logic                       drop_o
);

   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;

   // Only a stalled held word blocks a load; a word being accepted this
   // cycle frees the register for the incoming one.
   assign drop_o = load_i & valid_q & ~ready_i;

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i && !drop_o) begin
         word_d  = word_i;
         valid_d = 1'b1;
      end
      if (clr_ovf_i) begin
         ovf_d = 1'b0;
      end else if (drop_o) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_i) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign word_o     = word_q;
   assign valid_o    = valid_q;
   assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/adc_capture_packer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_packer
//  Description : ADC capture front end. Waits for a trigger once armed, keeps
//                (optionally decimated) samples, packs them LANES per word
//                with an over-range OR and trigger status bit, and hands
//                words to the capture FIFO over a valid/ready bus.
//  Ports       : adc_sampleclk     sole clock, rising edge
//                reset_i           synchronous active-low reset
//                adc_datain        sample data
//                adc_or            ADC over-range flag
//                adc_trig_status   trigger level
//                adc_capture_go    high arms/runs a capture, low aborts
//                max_samples_i     kept samples per capture
//                decimate_i        keep 1 of every decimate_i+1 samples
//                word_if           word bus (master): word_o, word_valid_o,
//                                  word_ready_i
//                adc_capture_stop  capture finished
//                overflow_o        sticky: a completed word was dropped
//                sample_count_o    kept samples in the current capture
//  Config      : ADC_PACKER_DECIMATE_EN - when defined, decimate_i is honoured
//                and the decimation counter is built; otherwise every capture
//                cycle's sample is kept.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module adc_capture_packer
   import adc_capture_pkg::*;
#(
   parameter int ADC_WIDTH  = 10,
   parameter int WORD_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  wire logic                 adc_sampleclk,
   input  wire logic                 reset_i,
   input  wire logic [ADC_WIDTH-1:0] adc_datain,
   input  wire logic                 adc_or,
   input  wire logic                 adc_trig_status,
   input  wire logic                 adc_capture_go,
   input  wire logic [CNT_WIDTH-1:0] max_samples_i,
   input  wire logic [15:0]          decimate_i,
   adc_capture_packer_if.master      word_if,
   output logic                      adc_capture_stop,
   output logic                      overflow_o,
   output logic      [CNT_WIDTH-1:0] sample_count_o
);

   localparam int LANES  = lanes_f(WORD_WIDTH, ADC_WIDTH);
   localparam int IDX_W  = idx_width_f(LANES);
   localparam int PACK_W = LANES * ADC_WIDTH;

   generate
      if (WORD_WIDTH < ADC_WIDTH + c_status_bits) begin : g_width_check
         $error("adc_capture_packer: WORD_WIDTH must be >= ADC_WIDTH+2");
      end
   endgenerate

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      lane_q, lane_d;
   logic [PACK_W-1:0]     acc_q, acc_d;
   logic                  or_q, or_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  stop_q, stop_d;

   logic                  keep_slot;
   logic                  keep;
   logic                  last_sample;
   logic                  lane_full;
   logic                  complete;
   logic                  drop;
   logic                  clr_ovf;
   logic [CNT_WIDTH-1:0]  count_inc;
   logic [PACK_W-1:0]     merged;
   logic [WORD_WIDTH-1:0] word_new;
   logic [WORD_WIDTH-1:0] out_word;
   logic                  out_valid;

   // ------------------------------------------------------------------------
   // Decimation slot: which capture cycles carry a kept sample.
   // ------------------------------------------------------------------------
`ifdef ADC_PACKER_DECIMATE_EN
   logic [15:0] dec_q, dec_d;

   // The trigger edge itself is slot 0, so the counter leaves ARMED already
   // advanced by one. '>=' guards against decimate_i shrinking mid-capture.
   always_comb begin
      dec_d = '0;
      if (adc_capture_go) begin
         if (state_q == ARMED && adc_trig_status) begin
            dec_d = (decimate_i == 16'd0) ? 16'd0 : 16'd1;
         end else if (state_q == CAPTURE) begin
            dec_d = (dec_q >= decimate_i) ? 16'd0 : dec_q + 16'd1;
         end
      end
   end

   always_ff @(posedge adc_sampleclk) begin
      if (!reset_i) begin
         dec_q <= '0;
      end else begin
         dec_q <= dec_d;
      end
   end

   assign keep_slot = (dec_q == 16'd0);
`else
   logic decimate_unused;
   assign decimate_unused = ^decimate_i;
   assign keep_slot       = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Sample keep / word completion
   // ------------------------------------------------------------------------
   always_comb begin
      keep = 1'b0;
      if (adc_capture_go) begin
         if (state_q == ARMED) begin
            keep = adc_trig_status && (max_samples_i != '0);
         end else if (state_q == CAPTURE) begin
            keep = keep_slot;
         end
      end
   end

   assign count_inc   = count_q + CNT_WIDTH'(1);
   assign last_sample = (count_inc >= max_samples_i);
   assign lane_full   = (lane_q == IDX_W'(LANES - 1));
   assign complete    = keep & (last_sample | lane_full);

   // Current sample dropped into its lane on top of the lanes already filled.
   always_comb begin
      merged = acc_q;
      for (int k = 0; k < LANES; k++) begin
         if (lane_q == IDX_W'(k)) begin
            merged[k*ADC_WIDTH +: ADC_WIDTH] = adc_datain;
         end
      end
   end

   always_comb begin
      word_new                             = '0;
      word_new[PACK_W-1:0]                 = merged;
      word_new[WORD_WIDTH-1-c_or_ofs]      = or_q | adc_or;
      word_new[WORD_WIDTH-1-c_trig_ofs]    = adc_trig_status;
   end

   // ------------------------------------------------------------------------
   // Capture state machine
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      acc_d   = acc_q;
      or_d    = or_q;
      count_d = count_q;
      stop_d  = stop_q;
      clr_ovf = 1'b0;

      case (state_q)
         IDLE: begin
            if (adc_capture_go) begin
               state_d = ARMED;
               count_d = '0;
               stop_d  = 1'b0;
               clr_ovf = 1'b1;
            end
         end
         ARMED: begin
            if (!adc_capture_go) begin
               state_d = IDLE;
            end else if (adc_trig_status) begin
               if (max_samples_i == '0) begin
                  state_d = DONE;
                  stop_d  = 1'b1;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            // Abort discards the partly filled word.
            if (!adc_capture_go) begin
               state_d = IDLE;
               lane_d  = '0;
               acc_d   = '0;
               or_d    = 1'b0;
            end
         end
         DONE: begin
            if (!adc_capture_go) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (keep) begin
         count_d = last_sample ? max_samples_i : count_inc;
         if (complete) begin
            lane_d = '0;
            acc_d  = '0;
            or_d   = 1'b0;
         end else begin
            lane_d = lane_q + IDX_W'(1);
            acc_d  = merged;
            or_d   = or_q | adc_or;
         end
         // A dropped word ends the capture just like reaching the count.
         if (last_sample || drop) begin
            state_d = DONE;
            stop_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge adc_sampleclk) begin
      if (!reset_i) begin
         state_q <= IDLE;
         lane_q  <= '0;
         acc_q   <= '0;
         or_q    <= 1'b0;
         count_q <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         acc_q   <= acc_d;
         or_q    <= or_d;
         count_q <= count_d;
         stop_q  <= stop_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   adc_word_outreg #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_outreg (
      .clk        (adc_sampleclk),
      .reset_i    (reset_i),
      .load_i     (complete),
      .word_i     (word_new),
      .clr_ovf_i  (clr_ovf),
      .ready_i    (word_if.word_ready_i),
      .word_o     (out_word),
      .valid_o    (out_valid),
      .overflow_o (overflow_o),
      .drop_o     (drop)
   );

   assign word_if.word_o       = out_word;
   assign word_if.word_valid_o = out_valid;
   assign adc_capture_stop     = stop_q;
   assign sample_count_o       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture_packer
//  Description : Directed self-checking bench for adc_capture_packer with the
//                default parameters (10-bit samples, 32-bit words, 3 lanes).
//                Expected words are hand-packed: lane k at bits [10k+9:10k],
//                bit 31 = over-range OR, bit 30 = trigger of last kept sample.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_capture_packer;

   localparam int ADC_WIDTH  = 10;
   localparam int WORD_WIDTH = 32;
   localparam int CNT_WIDTH  = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [ADC_WIDTH-1:0] adc_datain;
   logic                 adc_or;
   logic                 adc_trig_status;
   logic                 adc_capture_go;
   logic [CNT_WIDTH-1:0] max_samples;
   logic [15:0]          decimate;
   logic                 adc_capture_stop;
   logic                 overflow;
   logic [CNT_WIDTH-1:0] sample_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WORD_WIDTH-1:0] got_words[$];
   logic [WORD_WIDTH-1:0] exp_dec_w0;
   logic [WORD_WIDTH-1:0] exp_dec_w1;

   adc_capture_packer_if #(.WORD_WIDTH(WORD_WIDTH)) word_if ();

   adc_capture_packer #(
      .ADC_WIDTH  (ADC_WIDTH),
      .WORD_WIDTH (WORD_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .adc_sampleclk    (clk),
      .reset_i          (rst_n),
      .adc_datain       (adc_datain),
      .adc_or           (adc_or),
      .adc_trig_status  (adc_trig_status),
      .adc_capture_go   (adc_capture_go),
      .max_samples_i    (max_samples),
      .decimate_i       (decimate),
      .word_if          (word_if),
      .adc_capture_stop (adc_capture_stop),
      .overflow_o       (overflow),
      .sample_count_o   (sample_count)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp(input logic [ADC_WIDTH-1:0] d, input logic trig, input logic orr);
      adc_datain      = d;
      adc_trig_status = trig;
      adc_or          = orr;
      tick();
   endtask

   initial begin
      rst_n           = 1'b0;
      adc_datain      = '0;
      adc_or          = 1'b0;
      adc_trig_status = 1'b0;
      adc_capture_go  = 1'b0;
      max_samples     = 32'd6;
      decimate        = 16'd0;
      word_if.word_ready_i = 1'b1;

      // ---------------- reset state ----------------
      tick();
      chk_eq("rst_word",  word_if.word_o, 0);
      chk_eq("rst_valid", word_if.word_valid_o, 0);
      chk_eq("rst_stop",  adc_capture_stop, 0);
      chk_eq("rst_ovf",   overflow, 0);
      chk_eq("rst_count", sample_count, 0);

      // ---------------- max=6, trigger after a few idle samples ----------
      rst_n          = 1'b1;
      adc_capture_go = 1'b1;
      tick();                               // -> ARMED
      for (int i = 0; i < 4; i++) smp(10'h3FF, 1'b0, 1'b1);   // not kept
      chk_eq("armed_count", sample_count, 0);
      smp(10'd1, 1'b1, 1'b0);
      smp(10'd2, 1'b1, 1'b0);
      chk_eq("t1_no_word_yet", word_if.word_valid_o, 0);
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t1_w0_valid", word_if.word_valid_o, 1);
      chk_eq("t1_w0",       word_if.word_o, 32'h4030_0801);
      smp(10'd4, 1'b1, 1'b0);
      chk_eq("t1_w0_taken", word_if.word_valid_o, 0);
      smp(10'd5, 1'b1, 1'b0);
      smp(10'd6, 1'b0, 1'b0);
      chk_eq("t1_w1_valid", word_if.word_valid_o, 1);
      chk_eq("t1_w1",       word_if.word_o, 32'h0060_1404);
      chk_eq("t1_stop",     adc_capture_stop, 1);
      chk_eq("t1_count",    sample_count, 6);
      adc_capture_go = 1'b0;
      tick();

      // ---------------- max=4: partial final word ----------------
      max_samples    = 32'd4;
      adc_capture_go = 1'b1;
      tick();
      chk_eq("t2_arm_stop",  adc_capture_stop, 0);
      chk_eq("t2_arm_count", sample_count, 0);
      smp(10'd1, 1'b1, 1'b0);
      smp(10'd2, 1'b1, 1'b0);
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t2_w0", word_if.word_o, 32'h4030_0801);
      smp(10'd4, 1'b1, 1'b0);
      chk_eq("t2_w1_valid", word_if.word_valid_o, 1);
      chk_eq("t2_w1",       word_if.word_o, 32'h4000_0004);
      chk_eq("t2_stop",     adc_capture_stop, 1);
      chk_eq("t2_count",    sample_count, 4);
      adc_capture_go = 1'b0;
      tick();

      // ---------------- decimate=2, data 0..17, max=6 ----------------
`ifdef ADC_PACKER_DECIMATE_EN
      exp_dec_w0 = 32'h4060_0C00;           // kept 0,3,6
      exp_dec_w1 = 32'h40F0_3009;           // kept 9,12,15
`else
      exp_dec_w0 = 32'h4020_0400;           // decimate ignored: 0,1,2
      exp_dec_w1 = 32'h4050_1003;           // 3,4,5
`endif
      max_samples    = 32'd6;
      decimate       = 16'd2;
      adc_capture_go = 1'b1;
      tick();
      for (int i = 0; i < 18; i++) begin
         smp(ADC_WIDTH'(i), 1'b1, 1'b0);
         if (word_if.word_valid_o) got_words.push_back(word_if.word_o);
      end
      chk_eq("t3_nwords", got_words.size(), 2);
      if (got_words.size() >= 2) begin
         chk_eq("t3_w0", got_words[0], exp_dec_w0);
         chk_eq("t3_w1", got_words[1], exp_dec_w1);
      end
      chk_eq("t3_count", sample_count, 6);
      chk_eq("t3_stop",  adc_capture_stop, 1);
      decimate       = 16'd0;
      adc_capture_go = 1'b0;
      tick();

      // ---------------- ready=0 throughout, max=9: overflow ----------------
      word_if.word_ready_i = 1'b0;
      max_samples          = 32'd9;
      adc_capture_go       = 1'b1;
      tick();
      smp(10'd1, 1'b1, 1'b0);
      smp(10'd2, 1'b1, 1'b0);
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t4_w0_valid", word_if.word_valid_o, 1);
      chk_eq("t4_no_ovf",   overflow, 0);
      smp(10'd4, 1'b1, 1'b0);
      smp(10'd5, 1'b1, 1'b0);
      smp(10'd6, 1'b1, 1'b0);
      chk_eq("t4_ovf",      overflow, 1);
      chk_eq("t4_stop",     adc_capture_stop, 1);
      chk_eq("t4_held",     word_if.word_o, 32'h4030_0801);
      chk_eq("t4_held_vld", word_if.word_valid_o, 1);
      smp(10'd7, 1'b1, 1'b0);               // DONE: not kept
      chk_eq("t4_count", sample_count, 6);
      word_if.word_ready_i = 1'b1;
      tick();
      chk_eq("t4_drained", word_if.word_valid_o, 0);
      chk_eq("t4_ovf_sticky", overflow, 1);
      adc_capture_go = 1'b0;
      tick();

      // ---------------- over-range OR, max=3 ----------------
      max_samples    = 32'd3;
      adc_capture_go = 1'b1;
      tick();
      chk_eq("t5_arm_clr_ovf", overflow, 0);
      smp(10'd7, 1'b1, 1'b0);
      smp(10'd8, 1'b1, 1'b1);
      smp(10'd9, 1'b1, 1'b0);
      chk_eq("t5_w_or", word_if.word_o, 32'hC090_2007);
      adc_capture_go = 1'b0;
      tick();
      adc_capture_go = 1'b1;
      tick();
      smp(10'd1, 1'b1, 1'b0);
      smp(10'd2, 1'b1, 1'b0);
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t5_w_no_or", word_if.word_o, 32'h4030_0801);
      adc_capture_go = 1'b0;
      tick();

      // ---------------- abort mid-word, then clean recapture ----------------
      adc_capture_go = 1'b1;
      tick();
      smp(10'd1, 1'b1, 1'b1);
      smp(10'd2, 1'b1, 1'b0);
      chk_eq("t6_count2", sample_count, 2);
      adc_capture_go = 1'b0;
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t6_abort_novalid", word_if.word_valid_o, 0);
      chk_eq("t6_abort_nostop",  adc_capture_stop, 0);
      smp(10'd3, 1'b1, 1'b0);
      chk_eq("t6_idle_novalid", word_if.word_valid_o, 0);
      adc_capture_go = 1'b1;
      tick();
      smp(10'd4, 1'b1, 1'b0);
      smp(10'd5, 1'b1, 1'b0);
      smp(10'd6, 1'b1, 1'b0);
      chk_eq("t6_clean_word", word_if.word_o, 32'h4060_1404);
      adc_capture_go = 1'b0;
      tick();

      // abort never loses a held word
      word_if.word_ready_i = 1'b0;
      max_samples          = 32'd9;
      adc_capture_go       = 1'b1;
      tick();
      smp(10'd1, 1'b1, 1'b0);
      smp(10'd2, 1'b1, 1'b0);
      smp(10'd3, 1'b1, 1'b0);
      adc_capture_go = 1'b0;
      tick();
      chk_eq("t6_abort_keeps_vld",  word_if.word_valid_o, 1);
      chk_eq("t6_abort_keeps_word", word_if.word_o, 32'h4030_0801);

      // reset mid-capture
      adc_capture_go = 1'b1;
      tick();
      smp(10'd4, 1'b1, 1'b0);
      chk_eq("t6_pre_rst_count", sample_count, 1);
      rst_n = 1'b0;
      tick();
      chk_eq("t6_rst_word",  word_if.word_o, 0);
      chk_eq("t6_rst_valid", word_if.word_valid_o, 0);
      chk_eq("t6_rst_count", sample_count, 0);
      chk_eq("t6_rst_stop",  adc_capture_stop, 0);
      chk_eq("t6_rst_ovf",   overflow, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
